// File: rtl/dfp_bcd_sig_divider.sv
// Sequential BCD significand divider: q = floor(a*10^FD / b) by restoring digit recurrence,
// one SHIFT plus nine TRIAL clocks per quotient digit, with final remainder and sticky.
module dfp_bcd_sig_divider #(
  parameter int N  = 25,
  parameter int FD = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  ld,
  input  logic [N*4-1:0]        a,
  input  logic [N*4-1:0]        b,
  output logic [(N+FD)*4-1:0]   q,
  output logic [N*4-1:0]        r,
  output logic                  sticky,
  output logic                  dz,
  output logic                  busy,
  output logic                  done
);

  localparam int QD = N + FD;
  localparam int QW = QD * 4;
  localparam int PW = (N + 1) * 4;
  localparam int IW = (QD > 1) ? $clog2(QD) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, TRIAL, FIN} state_t;

  state_t          state;
  logic [QW-1:0]   d_reg;
  logic [N*4-1:0]  b_reg;
  logic [PW-1:0]   pr;
  logic [3:0]      qd;
  logic [3:0]      t;
  logic [IW-1:0]   i;

  // Digit-serial BCD subtract with borrow; caller guarantees x >= y.
  function automatic logic [PW-1:0] bcd_sub(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW-1:0]      res;
    logic               br;
    logic signed [5:0]  dd;
    logic signed [5:0]  adj;
    res = '0;
    br  = 1'b0;
    for (int k = 0; k < N + 1; k++) begin
      dd = $signed({2'b00, x[4*k +: 4]}) - $signed({2'b00, y[4*k +: 4]}) - $signed({5'b00000, br});
      if (dd < 0) begin
        adj = dd + 6'sd10;
        res[4*k +: 4] = adj[3:0];
        br = 1'b1;
      end else begin
        res[4*k +: 4] = dd[3:0];
        br = 1'b0;
      end
    end
    return res;
  endfunction

  logic [PW-1:0] b_ext;
  logic [PW-1:0] pr_sub;
  logic [PW-1:0] pr_shift;
  logic          pr_ge;
  logic [3:0]    qd_inc;
  logic [3:0]    qd_fin;

  // Valid BCD orders the same as its packed binary image, so a plain magnitude compare suffices.
  always_comb begin
    b_ext    = {4'h0, b_reg};
    pr_ge    = (pr >= b_ext);
    pr_sub   = bcd_sub(pr, b_ext);
    pr_shift = {pr[PW-5:0], d_reg[QW-1 -: 4]};
    qd_inc   = qd + 4'd1;
    qd_fin   = pr_ge ? qd_inc : qd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      d_reg  <= '0;
      b_reg  <= '0;
      pr     <= '0;
      qd     <= '0;
      t      <= '0;
      i      <= '0;
      q      <= '0;
      r      <= '0;
      sticky <= 1'b0;
      dz     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (ce) begin
      if (ld) begin
        d_reg  <= {a, {(FD*4){1'b0}}};
        b_reg  <= b;
        pr     <= '0;
        qd     <= '0;
        t      <= '0;
        i      <= '0;
        q      <= '0;
        r      <= '0;
        sticky <= 1'b0;
        if (b == '0) begin
          dz    <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          dz    <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
      end else begin
        case (state)
          SHIFT: begin
            pr    <= pr_shift;
            d_reg <= {d_reg[QW-5:0], 4'h0};
            qd    <= '0;
            t     <= '0;
            state <= TRIAL;
          end
          TRIAL: begin
            if (pr_ge) begin
              pr <= pr_sub;
              qd <= qd_inc;
            end
            if (t == 4'd8) begin
              q <= {q[QW-5:0], qd_fin};
              if (i == IW'(QD - 1)) begin
                state <= FIN;
              end else begin
                i     <= i + IW'(1);
                state <= SHIFT;
              end
            end else begin
              t <= t + 4'd1;
            end
          end
          FIN: begin
            r      <= pr[N*4-1:0];
            sticky <= |pr;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dfp_bcd_sig_divider.sv
// Scoreboard bench for dfp_bcd_sig_divider: a small N=FD=4 instance with directed vectors
// and a default-size instance checked against a wide-integer golden model.
module tb_dfp_bcd_sig_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s_ce, s_ld;
  logic [15:0] s_a, s_b;
  logic [31:0] s_q;
  logic [15:0] s_r;
  logic        s_sticky, s_dz, s_busy, s_done;

  logic         g_ce, g_ld;
  logic [99:0]  g_a, g_b;
  logic [199:0] g_q;
  logic [99:0]  g_r;
  logic         g_sticky, g_dz, g_busy, g_done;

  dfp_bcd_sig_divider #(.N(4), .FD(4)) u_small (
    .clk(clk), .rst_n(rst_n), .ce(s_ce), .ld(s_ld), .a(s_a), .b(s_b),
    .q(s_q), .r(s_r), .sticky(s_sticky), .dz(s_dz), .busy(s_busy), .done(s_done)
  );

  dfp_bcd_sig_divider u_big (
    .clk(clk), .rst_n(rst_n), .ce(g_ce), .ld(g_ld), .a(g_a), .b(g_b),
    .q(g_q), .r(g_r), .sticky(g_sticky), .dz(g_dz), .busy(g_busy), .done(g_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pow10(input int n);
    logic [255:0] v;
    v = 256'd1;
    for (int k = 0; k < n; k++) v = v * 256'd10;
    return v;
  endfunction

  function automatic logic [255:0] bcd2bin(input logic [255:0] x, input int nd);
    logic [255:0] v;
    v = '0;
    for (int k = nd - 1; k >= 0; k--) v = v * 256'd10 + 256'(x[4*k +: 4]);
    return v;
  endfunction

  function automatic logic [255:0] bin2bcd(input logic [255:0] x, input int nd);
    logic [255:0] v;
    logic [255:0] o;
    v = x;
    o = '0;
    for (int k = 0; k < nd; k++) begin
      o[4*k +: 4] = 4'(v % 256'd10);
      v = v / 256'd10;
    end
    return o;
  endfunction

  // ce-enabled edge counters give latency in enabled clocks
  int s_cnt = 0, g_cnt = 0;
  always @(posedge clk) begin
    if (s_ce) s_cnt <= s_cnt + 1;
    if (g_ce) g_cnt <= g_cnt + 1;
  end

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        sticky;
    logic        dz;
    int          lat;
    int          start;
    string       tag;
  } s_exp_t;

  typedef struct {
    logic [99:0] a;
    logic [99:0] b;
    int          start;
  } g_exp_t;

  s_exp_t s_sb[$];
  g_exp_t g_sb[$];
  s_exp_t s_e;
  g_exp_t g_e;

  int s_ld_id = 0, s_served = 0;
  int g_ld_id = 0, g_served = 0;

  // Small-instance monitor: one result per accepted ld that reaches done
  always @(negedge clk) begin
    if (rst_n && s_done && (s_served != s_ld_id)) begin
      s_served <= s_ld_id;
      if (s_sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL s_unexpected_done: got done=1 expected no result");
      end else begin
        s_e = s_sb.pop_front();
        check({s_e.tag, "_q"},      256'(s_q),      256'(s_e.q));
        check({s_e.tag, "_r"},      256'(s_r),      256'(s_e.r));
        check({s_e.tag, "_sticky"}, 256'(s_sticky), 256'(s_e.sticky));
        check({s_e.tag, "_dz"},     256'(s_dz),     256'(s_e.dz));
        check({s_e.tag, "_busy"},   256'(s_busy),   256'(0));
        check({s_e.tag, "_lat"},    256'(s_cnt - s_e.start), 256'(s_e.lat));
      end
    end
  end

  logic [255:0] m_a, m_b, m_num, m_q, m_r, d_q, d_r;

  // Default-size monitor: golden quotient plus the division identity on the DUT's own outputs
  always @(negedge clk) begin
    if (rst_n && g_done && (g_served != g_ld_id)) begin
      g_served <= g_ld_id;
      if (g_sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL g_unexpected_done: got done=1 expected no result");
      end else begin
        g_e   = g_sb.pop_front();
        m_a   = bcd2bin(256'(g_e.a), 25);
        m_b   = bcd2bin(256'(g_e.b), 25);
        m_num = m_a * pow10(25);
        m_q   = m_num / m_b;
        m_r   = m_num % m_b;
        d_q   = bcd2bin(256'(g_q), 50);
        d_r   = bcd2bin(256'(g_r), 25);
        check("big_q",        256'(g_q), bin2bcd(m_q, 50));
        check("big_r",        256'(g_r), bin2bcd(m_r, 25));
        check("big_sticky",   256'(g_sticky), 256'(m_r != 0));
        check("big_dz",       256'(g_dz), 256'(0));
        check("big_identity", d_q * m_b + d_r, m_num);
        check("big_r_lt_b",   256'(d_r < m_b), 256'(1));
        check("big_lat",      256'(g_cnt - g_e.start), 256'(501));
      end
    end
  end

  task automatic s_start(input logic [15:0] aa, input logic [15:0] bb);
    @(negedge clk);
    s_a  = aa;
    s_b  = bb;
    s_ld = 1'b1;
    s_ce = 1'b1;
    @(posedge clk);
    #1;
    s_ld = 1'b0;
    s_ld_id++;
  endtask

  task automatic s_push(input logic [31:0] qq, input logic [15:0] rr, input logic st,
                        input logic z, input int lat, input string tag);
    s_sb.push_back('{q: qq, r: rr, sticky: st, dz: z, lat: lat, start: s_cnt, tag: tag});
  endtask

  task automatic s_drain(input int maxc, input bit rand_ce);
    int n;
    n = 0;
    while (s_sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      if (rand_ce) s_ce = 1'($urandom_range(0, 1));
      n++;
    end
    s_ce = 1'b1;
    if (s_sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL s_timeout: got %0d pending results expected 0", s_sb.size());
      s_sb.delete();
    end
  endtask

  task automatic g_run(input logic [99:0] aa, input logic [99:0] bb);
    int n;
    @(negedge clk);
    g_a  = aa;
    g_b  = bb;
    g_ld = 1'b1;
    @(posedge clk);
    #1;
    g_ld = 1'b0;
    g_ld_id++;
    g_sb.push_back('{a: aa, b: bb, start: g_cnt});
    n = 0;
    while (g_sb.size() != 0 && n < 700) begin
      @(negedge clk);
      n++;
    end
    if (g_sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL g_timeout: got %0d pending results expected 0", g_sb.size());
      g_sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  logic [99:0] ra, rb;

  initial begin
    rst_n = 1'b0;
    s_ce = 1'b1; s_ld = 1'b0; s_a = '0; s_b = '0;
    g_ce = 1'b1; g_ld = 1'b0; g_a = '0; g_b = '0;
    #12;
    check("rst_q",      256'(s_q), 256'(0));
    check("rst_r",      256'(s_r), 256'(0));
    check("rst_flags",  256'({s_sticky, s_dz, s_busy, s_done}), 256'(0));
    check("rst_big",    256'({g_q, g_sticky, g_dz, g_busy, g_done}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    s_start(16'h0001, 16'h0003);
    s_push(32'h00003333, 16'h0001, 1'b1, 1'b0, 81, "c1");
    check("c1_busy_after_ld", 256'(s_busy), 256'(1));
    s_drain(200, 1'b0);

    s_start(16'h9999, 16'h0001);
    check("c2_ld_clears_done", 256'(s_done), 256'(0));
    s_push(32'h99990000, 16'h0000, 1'b0, 1'b0, 81, "c2");
    s_drain(200, 1'b0);

    s_start(16'h1234, 16'h0000);
    s_push(32'h00000000, 16'h0000, 1'b0, 1'b1, 0, "c3");
    s_drain(10, 1'b0);

    s_start(16'h0001, 16'h0003);
    repeat (29) @(posedge clk);
    s_start(16'h0004, 16'h0002);
    s_push(32'h00020000, 16'h0000, 1'b0, 1'b0, 81, "c4");
    s_drain(200, 1'b0);

    s_start(16'h0001, 16'h0003);
    s_push(32'h00003333, 16'h0001, 1'b1, 1'b0, 81, "c5");
    s_drain(1000, 1'b1);

    s_start(16'h0000, 16'h0007);
    s_push(32'h00000000, 16'h0000, 1'b0, 1'b0, 81, "azero");
    s_drain(200, 1'b0);

    s_start(16'h9999, 16'h9999);
    s_push(32'h00010000, 16'h0000, 1'b0, 1'b0, 81, "equal");
    s_drain(200, 1'b0);

    s_start(16'h0001, 16'h9999);
    s_push(32'h00000001, 16'h0001, 1'b1, 1'b0, 81, "small_q");
    s_drain(200, 1'b0);

    // Reset mid-operation: no result is expected from this load
    s_start(16'h0001, 16'h0003);
    repeat (39) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("c6_rst_q",     256'(s_q), 256'(0));
    check("c6_rst_r",     256'(s_r), 256'(0));
    check("c6_rst_flags", 256'({s_sticky, s_dz, s_busy, s_done}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("c6_no_done", 256'({s_busy, s_done}), 256'(0));

    g_run(100'h1234567890123456789012345, 100'h0000000000000000000000007);
    g_run(100'h0000000000000000000000001, 100'h9999999999999999999999999);
    g_run(100'h9999999999999999999999999, 100'h0000000000000000000000003);
    g_run(100'h3141592653589793238462643, 100'h2718281828459045235360287);
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 25; k++) begin
        ra[4*k +: 4] = 4'($urandom_range(0, 9));
        rb[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      if (rb == '0) rb = 100'h1;
      g_run(ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
